// File: rtl/fetch_pkg.sv
// fetch_pkg: constants and sizing helpers shared by the instruction-fetch queue
package fetch_pkg;
  localparam logic [31:0] NOP_INSN = 32'd0;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'd0;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: registered FIFO of {pc, insn}; flush beats push and pop
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  logic                      flush_i,
  input  logic [W-1:0]              din_i,
  output logic [W-1:0]              dout_o,
  output logic [cnt_w(DEPTH)-1:0]   count_o,
  output logic                      empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  assign do_push = push_i && !flush_i;
  assign do_pop = pop_i && !flush_i && count_q != '0;
  always_comb begin
    wr_d = flush_i ? '0 : do_push ? wr_q + AW'(1) : wr_q;
    rd_d = flush_i ? '0 : do_pop ? rd_q + AW'(1) : rd_q;
    count_d = flush_i ? '0 : count_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
  assign dout_o = mem_q[rd_q];
  assign count_o = count_q;
  assign empty_o = count_q == '0;
endmodule

// File: rtl/imem_fetch_queue.sv
// imem_fetch_queue: fetch PC, credit-limited imem requests and a decoded-side instruction queue
module imem_fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_resp_valid,
  input  logic [31:0]       imem_resp_data,
  output logic              inst_valid,
  output logic [31:0]       inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);
  localparam int CW = cnt_w(DEPTH);
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, q_count;
  logic [ADDR_W+31:0] head;
  logic fire, resp_ok, push, pop, empty;
  // queued plus in-flight words never exceed DEPTH, so responses need no back-pressure
  assign imem_req_valid = reset && !redirect_valid &&
                          ({1'b0, q_count} + {1'b0, out_q} < (CW+1)'(DEPTH));
  assign imem_req_addr = fetch_pc_q;
  assign fire = imem_req_valid && imem_req_ready;
  assign resp_ok = imem_resp_valid && out_q != '0;
  assign push = resp_ok && drop_q == '0 && !redirect_valid;
  assign pop = inst_valid && inst_ready;
  assign inst_valid = !empty;
  assign inst_data = empty ? NOP_INSN : head[31:0];
  assign inst_pc = empty ? resp_pc_q : head[ADDR_W+31:32];
  always_comb begin
    fetch_pc_d = redirect_valid ? redirect_pc : fire ? fetch_pc_q + ADDR_W'(1) : fetch_pc_q;
    resp_pc_d = redirect_valid ? redirect_pc : push ? resp_pc_q + ADDR_W'(1) : resp_pc_q;
    out_d = out_q + CW'(fire) - CW'(resp_ok);
    drop_d = redirect_valid ? out_q - CW'(resp_ok) : drop_q - CW'(resp_ok && drop_q != '0);
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q <= RESET_PC;
      out_q <= '0;
      drop_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q <= resp_pc_d;
      out_q <= out_d;
      drop_q <= drop_d;
    end
  end
  fetch_fifo #(.DEPTH(DEPTH), .W(ADDR_W + 32)) u_fifo (
    .clk_i  (clock),
    .rst_ni (reset),
    .push_i (push),
    .pop_i  (pop),
    .flush_i(redirect_valid),
    .din_i  ({resp_pc_q, imem_resp_data}),
    .dout_o (head),
    .count_o(q_count),
    .empty_o(empty)
  );
endmodule

// File: tb/tb_imem_fetch_queue.sv
// tb_imem_fetch_queue: in-order imem model plus a sequential-PC scoreboard for the fetch queue
module tb_imem_fetch_queue;
  localparam int DEPTH = 4;
  logic clock = 0, reset = 0;
  logic imem_req_valid, imem_req_ready, imem_resp_valid, inst_valid, inst_ready, redirect_valid;
  logic [31:0] imem_req_addr, imem_resp_data, inst_data, inst_pc, redirect_pc;
  imem_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(32), .RESET_PC(32'd0)) dut (
    .clock(clock), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );
  always #5 clock = ~clock;
  int nchk = 0, nfail = 0, cyc = 0, lat = 1, n_acc = 0, n_pop = 0;
  bit rq_rdy = 1, in_rdy = 1, redir = 0;
  logic [31:0] redir_pc = 0, exp_pc = 0, exp_req = 0;
  logic [31:0] pend_addr[$];
  int pend_due[$];
  logic [31:0] pop_hist[$];
  bit acc, ival, rv, popped, prev_hold;
  logic [31:0] ra, prev_pc, prev_data;
  function automatic logic [31:0] f(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF ^ {16'h0, a[31:16]};
  endfunction
  task automatic step();
    imem_resp_valid = pend_addr.size() > 0 && pend_due[0] <= cyc;
    imem_resp_data = imem_resp_valid ? f(pend_addr[0]) : 32'hDEAD_BEEF;
    imem_req_ready = rq_rdy;
    inst_ready = in_rdy;
    redirect_valid = redir;
    redirect_pc = redir_pc;
    #1;
    rv = imem_req_valid;
    ra = imem_req_addr;
    acc = imem_req_valid && imem_req_ready;
    ival = inst_valid;
    popped = inst_valid && inst_ready && !redir;
    if (prev_hold) begin
      nchk++;
      if (inst_pc !== prev_pc || inst_data !== prev_data) begin
        nfail++;
        $display("FAIL head_hold: pc %h data %h, required pc %h data %h", inst_pc, inst_data, prev_pc, prev_data);
      end
    end
    prev_hold = inst_valid && !inst_ready && !redir;
    prev_pc = inst_pc;
    prev_data = inst_data;
    if (acc) begin
      nchk++;
      if (ra !== exp_req) begin
        nfail++;
        $display("FAIL req_addr: got %h, required %h", ra, exp_req);
      end
      exp_req = exp_req + 1;
      pend_addr.push_back(ra);
      pend_due.push_back(cyc + lat);
      n_acc++;
    end
    if (popped) begin
      nchk++;
      if (inst_pc !== exp_pc || inst_data !== f(exp_pc)) begin
        nfail++;
        $display("FAIL stream: pc %h data %h, required pc %h data %h", inst_pc, inst_data, exp_pc, f(exp_pc));
      end
      pop_hist.push_back(inst_pc);
      exp_pc = exp_pc + 1;
      n_pop++;
    end
    if (dut.push) begin
      nchk++;
      if (dut.q_count == DEPTH) begin
        nfail++;
        $display("FAIL overflow: push with count %0d, required < %0d", dut.q_count, DEPTH);
      end
    end
    if (imem_resp_valid) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (redir) begin
      exp_pc = redir_pc;
      exp_req = redir_pc;
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask
  task automatic clear_model();
    pend_addr.delete();
    pend_due.delete();
    pop_hist.delete();
    exp_pc = 0;
    exp_req = 0;
    prev_hold = 0;
    n_acc = 0;
    n_pop = 0;
    redir = 0;
    imem_resp_valid = 0;
  endtask
  task automatic do_reset();
    reset = 0;
    clear_model();
    @(posedge clock);
    @(negedge clock);
    reset = 1;
  endtask
  task automatic wait_pops(input int n);
    for (int k = 0; k < 60 && n_pop < n; k++) step();
    nchk++;
    if (n_pop < n) begin
      nfail++;
      $display("FAIL pop_timeout: got %0d pops, required %0d", n_pop, n);
    end
  endtask
  task automatic test_reset();
    imem_req_ready = 1;
    inst_ready = 1;
    redirect_valid = 0;
    redirect_pc = 0;
    imem_resp_valid = 0;
    imem_resp_data = 0;
    #1;
    nchk += 5;
    if (imem_req_valid !== 1'b0) begin nfail++; $display("FAIL rst_req_valid: got %b, required 0", imem_req_valid); end
    if (inst_valid !== 1'b0) begin nfail++; $display("FAIL rst_inst_valid: got %b, required 0", inst_valid); end
    if (inst_data !== 32'd0) begin nfail++; $display("FAIL rst_inst_data: got %h, required 0", inst_data); end
    if (inst_pc !== 32'd0) begin nfail++; $display("FAIL rst_inst_pc: got %h, required 0", inst_pc); end
    if (imem_req_addr !== 32'd0) begin nfail++; $display("FAIL rst_req_addr: got %h, required 0", imem_req_addr); end
    @(negedge clock);
    do_reset();
  endtask
  task automatic test_stream();
    int c0 = -1, c1 = -1;
    do_reset();
    lat = 1; rq_rdy = 1; in_rdy = 1;
    for (int k = 0; k < 12; k++) begin
      step();
      if (acc && c0 < 0) c0 = k;
      if (ival && c1 < 0) c1 = k;
    end
    nchk += 3;
    if (c1 - c0 != 2) begin nfail++; $display("FAIL stream_latency: got %0d, required 2", c1 - c0); end
    if (n_pop != 10) begin nfail++; $display("FAIL stream_pops: got %0d, required 10", n_pop); end
    if (n_acc != 12) begin nfail++; $display("FAIL stream_accepts: got %0d, required 12", n_acc); end
  endtask
  task automatic test_backpressure();
    logic [31:0] resume = 32'hFFFF_FFFF;
    do_reset();
    lat = 1; rq_rdy = 1; in_rdy = 0;
    for (int k = 0; k < 10; k++) step();
    nchk += 2;
    if (n_acc != DEPTH) begin nfail++; $display("FAIL bp_accepts: got %0d, required %0d", n_acc, DEPTH); end
    if (imem_req_valid !== 1'b0) begin nfail++; $display("FAIL bp_req_valid: got %b, required 0", imem_req_valid); end
    in_rdy = 1;
    for (int k = 0; k < 8; k++) begin
      step();
      if (acc && resume == 32'hFFFF_FFFF) resume = ra;
    end
    nchk++;
    if (resume !== 32'd4) begin nfail++; $display("FAIL bp_resume: got %h, required 4", resume); end
    for (int i = 0; i < 4; i++) begin
      nchk++;
      if (pop_hist.size() <= i || pop_hist[i] !== 32'(i)) begin
        nfail++;
        $display("FAIL bp_drain_%0d: got %h, required %h", i, pop_hist.size() > i ? pop_hist[i] : 32'hX, i);
      end
    end
  endtask
  task automatic test_req_stall();
    do_reset();
    lat = 1; rq_rdy = 0; in_rdy = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      nchk++;
      if (rv !== 1'b1 || ra !== 32'd0) begin nfail++; $display("FAIL stall_hold: valid %b addr %h, required 1 / 0", rv, ra); end
    end
    rq_rdy = 1;
    step();
    nchk++;
    if (acc !== 1'b1 || ra !== 32'd0) begin nfail++; $display("FAIL stall_accept: acc %b addr %h, required 1 / 0", acc, ra); end
    step();
    nchk++;
    if (ra !== 32'd1) begin nfail++; $display("FAIL stall_advance: got %h, required 1", ra); end
  endtask
  task automatic test_redirect_drop();
    do_reset();
    lat = 3; rq_rdy = 1; in_rdy = 1;
    step(); step();
    rq_rdy = 0; redir = 1; redir_pc = 32'h40;
    step();
    redir = 0; rq_rdy = 1;
    step();
    nchk += 2;
    if (n_acc < 2) begin nfail++; $display("FAIL drop_setup: got %0d accepts, required >= 2", n_acc); end
    if (ival !== 1'b0) begin nfail++; $display("FAIL drop_valid: got %b, required 0", ival); end
    wait_pops(2);
    nchk++;
    if (pop_hist.size() < 2 || pop_hist[0] !== 32'h40 || pop_hist[1] !== 32'h41) begin
      nfail++; $display("FAIL drop_target: first pcs not 40,41 (%0d popped)", pop_hist.size());
    end
  endtask
  task automatic test_redirect_resp_pop();
    do_reset();
    lat = 3; rq_rdy = 1; in_rdy = 0;
    for (int k = 0; k < 4; k++) step();
    in_rdy = 1; redir = 1; redir_pc = 32'h100;
    step();
    nchk += 3;
    if (ival !== 1'b1) begin nfail++; $display("FAIL rrp_head: got %b, required 1", ival); end
    if (rv !== 1'b0) begin nfail++; $display("FAIL rrp_req_valid: got %b, required 0", rv); end
    if (n_acc != 4) begin nfail++; $display("FAIL rrp_accepts: got %0d, required 4", n_acc); end
    redir = 0;
    step();
    nchk++;
    if (ival !== 1'b0) begin nfail++; $display("FAIL rrp_flushed: got %b, required 0", ival); end
    wait_pops(2);
    nchk++;
    if (pop_hist.size() < 2 || pop_hist[0] !== 32'h100 || pop_hist[1] !== 32'h101) begin
      nfail++; $display("FAIL rrp_target: first pcs not 100,101 (%0d popped)", pop_hist.size());
    end
  endtask
  task automatic test_wrap();
    do_reset();
    lat = 1; rq_rdy = 1; in_rdy = 1; redir = 1; redir_pc = 32'hFFFF_FFFF;
    step();
    redir = 0;
    wait_pops(3);
    nchk++;
    if (pop_hist.size() < 3 || pop_hist[0] !== 32'hFFFF_FFFF || pop_hist[1] !== 32'h0 || pop_hist[2] !== 32'h1) begin
      nfail++; $display("FAIL wrap: pcs not FFFFFFFF,0,1 (%0d popped)", pop_hist.size());
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    lat = 2; rq_rdy = 1; in_rdy = 1;
    for (int k = 0; k < 8; k++) step();
    nchk++;
    if (inst_valid !== 1'b1 || imem_req_valid !== 1'b1) begin
      nfail++; $display("FAIL mid_pre: valid %b req %b, required 1 / 1", inst_valid, imem_req_valid);
    end
    #3 reset = 0;
    #1;
    nchk += 3;
    if (imem_req_valid !== 1'b0) begin nfail++; $display("FAIL mid_req_valid: got %b, required 0", imem_req_valid); end
    if (inst_valid !== 1'b0) begin nfail++; $display("FAIL mid_inst_valid: got %b, required 0", inst_valid); end
    if (inst_pc !== 32'd0) begin nfail++; $display("FAIL mid_inst_pc: got %h, required 0", inst_pc); end
    clear_model();
    @(negedge clock);
    reset = 1;
    pend_addr.push_back(32'h777);
    pend_due.push_back(cyc);
    wait_pops(3);
    nchk++;
    if (pop_hist.size() < 3 || pop_hist[0] !== 32'h0 || pop_hist[1] !== 32'h1 || pop_hist[2] !== 32'h2) begin
      nfail++; $display("FAIL mid_restart: pcs not 0,1,2 (%0d popped)", pop_hist.size());
    end
  endtask
  task automatic test_random();
    do_reset();
    for (int k = 0; k < 500; k++) begin
      lat = $urandom_range(1, 4);
      rq_rdy = $urandom_range(0, 3) != 0;
      in_rdy = $urandom_range(0, 9) < 7;
      redir = $urandom_range(0, 29) == 0;
      redir_pc = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFE : $urandom;
      step();
    end
    redir = 0;
    nchk++;
    if (n_pop < 50) begin nfail++; $display("FAIL random_progress: got %0d pops, required >= 50", n_pop); end
  endtask
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_req_stall();
    test_redirect_drop();
    test_redirect_resp_pop();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/imem_fetch_queue.md
Name: imem_fetch_queue

Overview:
- Instruction-fetch front end between instruction memory and the FD pipeline register.
- Holds the fetch PC and issues word-addressed requests (PC+1 per instruction) to a multi-cycle, in-order instruction memory.
- Buffers returned words with their PCs in a small queue; the decode stage drains it through a valid/ready handshake.
- On branch/jump redirect from execute, the queue is flushed and in-flight responses are discarded.

Parameters:
DEPTH, 4, queue entries; power of two, >= 2; also the cap on queued + in-flight requests
ADDR_W, 32, PC / imem address width
RESET_PC, 0, fetch PC after reset

Ports:
clock  input  1  master clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
imem_req_valid  output  1  request to imem is presented
imem_req_addr  output  ADDR_W  word address requested
imem_req_ready  input  1  imem accepts the request this cycle
imem_resp_valid  input  1  imem returns one word this cycle; in request order
imem_resp_data  input  32  returned instruction word
inst_valid  output  1  queue head holds an instruction
inst_data  output  32  queue head instruction
inst_pc  output  ADDR_W  PC of queue head
inst_ready  input  1  decode consumes the head (deasserted on pipeline stall)
redirect_valid  input  1  branch/jump taken; flush and refetch
redirect_pc  input  ADDR_W  new fetch PC

Behaviour:
- Reset (reset=0, immediate, no clock edge required):
  - fetch_pc = resp_pc = RESET_PC; queue empty; outstanding = drop_cnt = 0.
  - Outputs: imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=RESET_PC.
  - imem_req_addr = fetch_pc.
- Counters are $clog2(DEPTH)+1 bits wide. "outstanding" counts every accepted request not yet answered, including those to be dropped.
- Issue:
  - imem_req_valid = reset released && !redirect_valid && (count + outstanding < DEPTH).
  - imem_req_addr = fetch_pc. Both are held stable while imem_req_ready=0.
  - On valid && ready: fetch_pc <= fetch_pc + 1 (wraps modulo 2^ADDR_W); outstanding++.
- Response, when imem_resp_valid=1 and outstanding>0:
  - outstanding--.
  - If drop_cnt>0: discard the word, drop_cnt--.
  - Else: push {resp_pc, data} into the queue; resp_pc++.
  - imem_resp_valid with outstanding=0 is a protocol error and is ignored.
- Credit rule:
  - The queue can never overflow and responses are never back-pressured.
  - A push into a full queue is impossible by construction; the bench asserts it never occurs.
- Output:
  - Registered queue: a word pushed on edge N is visible from cycle N+1.
  - Minimum latency is request accept (cycle 0) -> imem response (cycle L) -> inst_valid (cycle L+1).
  - Pop on inst_valid && inst_ready. Push and pop in the same cycle are both performed; count is unchanged.
  - With inst_ready=0, head outputs stay stable.
- Redirect (redirect_valid=1 at the edge) has highest priority:
  - Queue cleared and any pop ignored.
  - fetch_pc <= redirect_pc; resp_pc <= redirect_pc.
  - No request is issued that cycle.
  - Any same-cycle response is discarded.
  - drop_cnt <= outstanding - (imem_resp_valid ? 1 : 0).
  - From the next cycle, inst_valid=0 until the first post-redirect word arrives.
- Back-to-back redirects: each one recomputes drop_cnt from the current outstanding count; only the last redirect_pc takes effect.
- Reset asserted mid-operation: all state clears immediately. In-flight imem responses after reset release are ignored because outstanding=0.

Decomposition:
- Shared package fetch_pkg:
  - constant NOP_INSN = 32'd0
  - default RESET_PC
  - localparam helper for the counter width $clog2(DEPTH)+1
- Sub-module fetch_fifo:
  - Synchronous FIFO of {pc, insn}.
  - Same async active-low reset.
  - Ports: push, pop, flush, count, empty.
  - Flush has priority over push and pop.
- Top level holds fetch_pc, resp_pc, the outstanding/drop counters and the issue logic.

Test Plan:
- Reset release, imem latency 1, imem_req_ready=1, inst_ready=1 -> addresses 0,1,2,3… issued every cycle; first inst_valid 2 cycles after the first accept, with inst_pc=0; then consecutive PCs with matching data.
- inst_ready=0 from start, DEPTH=4 -> exactly 4 requests accepted, then imem_req_valid=0 with count=4. Raise inst_ready -> 0,1,2,3 drain in order and issue resumes at address 4.
- imem_req_ready=0 for 5 cycles -> imem_req_valid=1 and imem_req_addr held constant, fetch_pc unchanged; the accept then increments it.
- Latency 3, 2 requests in flight, redirect_pc=0x40 -> both responses dropped, no inst_valid for them; next delivered inst_pc=0x40, then 0x41.
- Redirect in the same cycle as imem_resp_valid and a pop, outstanding=3 -> queue empty next cycle, drop_cnt=2, the next 2 responses discarded.
- Redirect to 0xFFFFFFFF -> delivered inst_pc sequence 0xFFFFFFFF, 0x00000000. Assert reset mid-stream -> inst_valid and imem_req_valid go 0 without a clock edge, and fetch restarts at RESET_PC.
